timer_seq_ctrl: RTL

Sequencing controller for the MM:SS BCD stopwatch/countdown datapath: counter, target register and 7-segment display.
- Takes debounced one-pulse buttons and the run switch.
- Walks the user through direction select, 4-digit target entry, load, run/pause and completion.
- Issues single-cycle command strobes and the count tick to the datapath.
- Owns the tick divider and the completion alarm; holds no BCD digits itself.

---
 rtl/timer_seq_ctrl_pkg.sv | 23 ++
 rtl/timer_seq_ctrl_tick_gen.sv | 34 +++
 rtl/timer_seq_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/timer_seq_ctrl_pkg.sv
// Shared definitions for the stopwatch/countdown sequencing controller.
//   state_t : controller states, encodings are visible on the debug port
//   MIN_T..SEC_O : digit_sel index of each BCD digit (3 = leftmost)
//   UP/DOWN : count direction values driven on dir
package timer_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    DIR_SET = 3'd0,
    NUM_SET = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MIN_T = 2'd3;
  localparam logic [1:0] MIN_O = 2'd2;
  localparam logic [1:0] SEC_T = 2'd1;
  localparam logic [1:0] SEC_O = 2'd0;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/timer_seq_ctrl_tick_gen.sv
// Divider producing one wrap strobe every TICK_DIV enabled cycles.
//   clk, rst : clock, async active-high reset
//   en       : advance the divider this cycle (holds when low)
//   clr      : synchronous clear, wins over en
//   wrap     : combinational, high in the enabled cycle at TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = en && !clr && (cnt == LAST);

  // cnt never exceeds LAST, so the increment cannot overflow its width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Sequencing controller for the MM:SS BCD stopwatch/countdown datapath.
// Walks the user through direction select, target entry, load, run/pause
// and completion; issues one-cycle command strobes and the count tick.
//   inputs : enter_p, inc_p, dir_p (one-cycle pulses), run_en (level),
//            at_zero, at_target (datapath compares)
//   outputs: dir, digit_sel, blank, done, alarm (levels), state (debug),
//            digit_inc, clr, load_target, load_start, tick (strobes)
// All outputs are registered; strobes follow their cause by one cycle.
module timer_seq_ctrl
  import timer_seq_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 10000000,
  parameter int ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_p,
  input  logic       inc_p,
  input  logic       dir_p,
  input  logic       run_en,
  input  logic       at_zero,
  input  logic       at_target,
  output logic       dir,
  output logic [1:0] digit_sel,
  output logic       digit_inc,
  output logic       clr,
  output logic       load_target,
  output logic       load_start,
  output logic       tick,
  output logic       blank,
  output logic [2:0] state,
  output logic       done,
  output logic       alarm
);

  localparam int AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ACNT_MAX = AW'(ALARM_TICKS);

  state_t        state_q, state_n;
  logic          dir_n, blank_n, done_n, alarm_n;
  logic [1:0]    sel_n;
  logic          inc_n, clr_n, lt_n, ls_n, tick_n;
  logic [AW-1:0] acnt, acnt_n;
  logic          div_en, div_clr, div_wrap, terminal;

  // One divider serves both the count tick in RUN and the alarm time base
  // in DONE; it is cleared on entry to each so both start at a known phase.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .wrap (div_wrap)
  );

  assign terminal = (dir == DOWN) ? at_zero : at_target;
  assign state    = state_q;

  always_comb begin
    state_n = state_q;
    dir_n   = dir;
    sel_n   = digit_sel;
    blank_n = blank;
    done_n  = done;
    alarm_n = alarm;
    acnt_n  = acnt;
    inc_n   = 1'b0;
    clr_n   = 1'b0;
    lt_n    = 1'b0;
    ls_n    = 1'b0;
    tick_n  = 1'b0;
    div_en  = 1'b0;
    div_clr = 1'b0;
    case (state_q)
      DIR_SET: begin
        blank_n = 1'b1;
        div_clr = 1'b1;
        if (dir_p) dir_n = ~dir;
        if (enter_p) begin
          state_n = NUM_SET;
          clr_n   = 1'b1;
          sel_n   = MIN_T;
          blank_n = 1'b0;
        end
      end
      NUM_SET: begin
        div_clr = 1'b1;
        if (enter_p) begin
          if (digit_sel != SEC_O) begin
            sel_n = digit_sel - 2'd1;
          end else begin
            lt_n    = 1'b1;
            state_n = LOAD;
          end
        end else if (inc_p) begin
          inc_n = 1'b1;
        end
      end
      LOAD: begin
        ls_n    = 1'b1;
        div_clr = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        if (terminal) begin
          state_n = DONE;
          done_n  = 1'b1;
          alarm_n = 1'b1;
          acnt_n  = '0;
          div_clr = 1'b1;
        end else begin
          div_en = run_en;
          tick_n = div_wrap;
        end
      end
      DONE: begin
        div_en = 1'b1;
        if (div_wrap && acnt != ACNT_MAX) acnt_n = acnt + 1'b1;
        // once cleared the alarm stays low; the counter saturates at max
        alarm_n = alarm && (acnt_n != ACNT_MAX);
        if (enter_p) begin
          state_n = DIR_SET;
          clr_n   = 1'b1;
          blank_n = 1'b1;
          done_n  = 1'b0;
          alarm_n = 1'b0;
          acnt_n  = '0;
          div_clr = 1'b1;
        end
      end
      default: begin
        state_n = DIR_SET;
        blank_n = 1'b1;
        done_n  = 1'b0;
        alarm_n = 1'b0;
        acnt_n  = '0;
        div_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIR_SET;
      dir         <= UP;
      digit_sel   <= MIN_T;
      blank       <= 1'b1;
      done        <= 1'b0;
      alarm       <= 1'b0;
      acnt        <= '0;
      digit_inc   <= 1'b0;
      clr         <= 1'b0;
      load_target <= 1'b0;
      load_start  <= 1'b0;
      tick        <= 1'b0;
    end else begin
      state_q     <= state_n;
      dir         <= dir_n;
      digit_sel   <= sel_n;
      blank       <= blank_n;
      done        <= done_n;
      alarm       <= alarm_n;
      acnt        <= acnt_n;
      digit_inc   <= inc_n;
      clr         <= clr_n;
      load_target <= lt_n;
      load_start  <= ls_n;
      tick        <= tick_n;
    end
  end

endmodule
